// File: rtl/conv_frame_writer.sv
// Output frame buffer for the convolution pipeline: clamps signed filter results to
// unsigned pixels, stores one frame in raster order, then serves it through a 1-cycle read port.
module conv_frame_writer #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int IN_W  = 12,
    parameter int DW    = 8,
    parameter int AW    = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            in_ready,
    output logic            busy,
    output logic            frame_done,
    output logic            ready_rd,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data,
    output logic            rd_valid
);

    localparam int DEPTH  = IMG_W * IMG_H;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [AW:0] DEPTH_A = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FULL
    } state_t;

    state_t          state;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [DW-1:0]   sat_data;
    logic [MEM_AW-1:0] wr_addr;
    logic            accept;
    logic            last_beat;
    logic            rd_in_range;

    logic [DW-1:0]   mem [DEPTH];

    // start has priority over a beat offered in the same cycle; that beat is dropped.
    assign accept    = in_valid & in_ready & ~start;
    assign last_beat = accept && (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign wr_addr   = MEM_AW'(row) * MEM_AW'(IMG_W) + MEM_AW'(col);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_A);

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sat_data = in_data[DW-1:0];
        if (in_data[IN_W-1]) begin
            sat_data = '0;
        end else if (|in_data[IN_W-2:DW]) begin
            sat_data = '1;
        end
    end

    // Status flags are registered alongside the state so they change only on clock edges.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            row        <= '0;
            col        <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            ready_rd   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start) begin
                state    <= S_FILL;
                row      <= '0;
                col      <= '0;
                in_ready <= 1'b1;
                busy     <= 1'b1;
                ready_rd <= 1'b0;
            end else if (accept) begin
                if (last_beat) begin
                    state      <= S_FULL;
                    row        <= '0;
                    col        <= '0;
                    in_ready   <= 1'b0;
                    busy       <= 1'b0;
                    ready_rd   <= 1'b1;
                    frame_done <= 1'b1;
                end else if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // NOTE: the frame buffer has no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= sat_data;
        end
    end

    // ready_rd mirrors state==FULL, so a read issued alongside start is still served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (ready_rd && rd_en) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_in_range ? mem[rd_addr[MEM_AW-1:0]] : '0;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_frame_writer.sv
// Randomized bench for conv_frame_writer: a frame-level reference model feeds expected
// frame_done pulses and read data into queues that a negedge monitor drains.
module tb_conv_frame_writer;

    localparam int IMG_W = 64;
    localparam int IMG_H = 64;
    localparam int IN_W  = 12;
    localparam int DW    = 8;
    localparam int AW    = 13;
    localparam int DEPTH = IMG_W * IMG_H;

    logic            clk;
    logic            rst;
    logic            start;
    logic            in_valid;
    logic [IN_W-1:0] in_data;
    logic            in_ready;
    logic            busy;
    logic            frame_done;
    logic            ready_rd;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic            rd_valid;

    conv_frame_writer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .IN_W(IN_W), .DW(DW), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .busy(busy), .frame_done(frame_done), .ready_rd(ready_rd),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum { M_IDLE, M_FILL, M_FULL } mstate_t;
    typedef struct { int cyc; int data; } rd_exp_t;

    mstate_t m_state = M_IDLE;
    int      ptr = 0;
    int      last_rd = 0;
    int      ref_mem [DEPTH];
    rd_exp_t rd_q [$];
    int      fd_q [$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int clamp(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int rand_sample();
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // One clock of stimulus: check status against the model, drive, advance the model.
    task automatic cycle(input logic st, input logic v, input int d, input logic re, input int ra);
        rd_exp_t e;
        @(negedge clk);
        check("in_ready", in_ready, m_state == M_FILL);
        check("busy", busy, m_state == M_FILL);
        check("ready_rd", ready_rd, m_state == M_FULL);
        start    = st;
        in_valid = v;
        in_data  = d[IN_W-1:0];
        rd_en    = re;
        rd_addr  = ra[AW-1:0];
        if (re && m_state == M_FULL) begin
            e.cyc  = cyc + 1;
            e.data = (ra < DEPTH) ? ref_mem[ra] : 0;
            rd_q.push_back(e);
            last_rd = e.data;
        end
        if (st) begin
            m_state = M_FILL;
            ptr = 0;
        end else if (v && m_state == M_FILL) begin
            ref_mem[ptr] = clamp(d);
            ptr++;
            if (ptr == DEPTH) begin
                fd_q.push_back(cyc + 1);
                m_state = M_FULL;
                ptr = 0;
            end
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ready_rd", ready_rd, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        #1 rst = 1'b0;
        m_state = M_IDLE;
        ptr = 0;
        last_rd = 0;
        rd_q.delete();
        fd_q.delete();
    endtask

    // Monitor: compares every frame_done pulse and read response against the queues.
    initial begin
        rd_exp_t e;
        int      fd_c;
        logic    exp_fd, exp_v;
        forever begin
            @(negedge clk);
            exp_fd = (fd_q.size() > 0) && (fd_q[0] == cyc);
            if (exp_fd || frame_done) begin
                check("frame_done", frame_done, exp_fd);
                if (exp_fd) fd_c = fd_q.pop_front();
            end
            exp_v = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
            if (exp_v || rd_valid) begin
                check("rd_valid", rd_valid, exp_v);
                if (exp_v) begin
                    e = rd_q.pop_front();
                    check("rd_data", rd_data, e.data);
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cyc);
        $fatal(1);
    end

    int sat_vals [6] = '{-5, 0, 255, 256, 2047, -2048};

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_ready_rd", ready_rd, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        rst = 1'b0;

        // Read in IDLE is ignored.
        cycle(0, 0, 0, 1, 7);
        @(negedge clk);
        check("idle_rd_valid", rd_valid, 0);
        check("idle_rd_data", rd_data, 0);

        // Full frame of idx mod 256, continuous valid, then full readout.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 1, i % 256, 0, 0);
        for (int a = 0; a < DEPTH; a++) cycle(0, 0, 0, 1, a);
        cycle(0, 0, 0, 1, 63);
        cycle(0, 0, 0, 1, 64);
        cycle(0, 0, 0, 1, 4095);
        cycle(0, 0, 0, 1, 4096);

        // start in FULL with a read in the same cycle; then a read in FILL is ignored.
        cycle(1, 0, 0, 1, 10);
        cycle(0, 0, 0, 1, 20);
        @(negedge clk);
        check("fill_rd_valid", rd_valid, 0);
        check("fill_rd_data", rd_data, last_rd);

        // Saturation corners at addresses 0..5, then random data with ~30% idle beats.
        while (m_state == M_FILL) begin
            cycle(0, $urandom_range(0, 99) >= 30, (ptr < 6) ? sat_vals[ptr] : rand_sample(), 0, 0);
        end
        for (int a = 0; a < 6; a++) cycle(0, 0, 0, 1, a);
        for (int i = 0; i < 300; i++) cycle(0, 0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 8191));

        // Restart at beat 100 with a beat offered in the same cycle.
        cycle(1, 0, 0, 0, 0);
        while (ptr < 100) cycle(0, 1, rand_sample(), 0, 0);
        cycle(1, 1, rand_sample(), 0, 0);
        while (m_state == M_FILL) cycle(0, 1, rand_sample(), 0, 0);
        for (int a = 0; a < 4; a++) cycle(0, 0, 0, 1, a);
        for (int i = 0; i < 200; i++) cycle(0, 0, 0, 1, $urandom_range(0, DEPTH - 1));

        // Asynchronous reset mid-frame, then a fresh frame must start at address 0.
        cycle(1, 0, 0, 0, 0);
        while (ptr < 2000) cycle(0, 1, rand_sample(), 0, 0);
        async_reset();
        cycle(0, 1, 123, 0, 0);
        cycle(1, 0, 0, 0, 0);
        while (m_state == M_FILL) cycle(0, $urandom_range(0, 99) >= 30, rand_sample(), 0, 0);
        for (int a = 0; a < 4; a++) cycle(0, 0, 0, 1, a);
        for (int i = 0; i < 100; i++) cycle(0, 0, 0, 1, $urandom_range(0, 8191));

        repeat (3) cycle(0, 0, 0, 0, 0);
        check("rd_q_drained", rd_q.size(), 0);
        check("fd_q_drained", fd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
